// File: rtl/reg_dump_port.sv
// reg_dump_port: architectural-state readout responder.
// Snoops ROB commit writes into a shadow register file. Detects end of
// program as a halt followed by IDLE_CYCLES quiet cycles. Then raises a
// sticky done flag. The read port is registered, has one cycle of latency
// and is served in every state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal execution, commits update the shadow file
// ST_DRAIN | halt seen, counting consecutive quiet cycles
// ST_DONE  | shadow file final, commits rejected and flagged late
module reg_dump_port #(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int IDLE_CYCLES = 16,
    localparam int AW         = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int CW         = $clog2(IDLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [AW-1:0]   commit_rd,
    input  logic [XLEN-1:0] commit_data,
    input  logic            halt,
    input  logic            rob_empty,
    input  logic [AW-1:0]   reg_addr,
    output logic [XLEN-1:0] reg_data,
    output logic            done,
    output logic            late_commit
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] shadow [NREG];
    logic [XLEN-1:0] rd_d;
    logic            wr_en;
    logic            quiet;
    logic            late_set;
    logic            rd_in_range;

    // x0 writes and out-of-range indices are dropped; DONE freezes the file.
    assign wr_en = commit_valid && (commit_rd != '0) &&
                   (32'(commit_rd) < NREG) && (state_q != ST_DONE);
    assign quiet = rob_empty && !commit_valid;
    assign rd_in_range = 32'(reg_addr) < NREG;

    // Next-state and idle-counter logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        late_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == IDLE_MAX) begin
                    state_d = ST_DONE;
                end
                if (!quiet) begin
                    cnt_d = '0;
                end else if (cnt_q != IDLE_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                late_set = commit_valid;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Read mux: x0 reads zero, a same-cycle commit to the address bypasses.
    always_comb begin
        rd_d = '0;
        if (reg_addr != '0) begin
            if (wr_en && (commit_rd == reg_addr)) begin
                rd_d = commit_data;
            end else if (rd_in_range) begin
                rd_d = shadow[reg_addr];
            end
        end
    end

    // Control state, read data and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            reg_data    <= '0;
            done        <= 1'b0;
            late_commit <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_data    <= rd_d;
            done        <= (state_d == ST_DONE);
            late_commit <= late_commit | late_set;
        end
    end

    // Shadow register file, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[commit_rd] <= commit_data;
        end
    end

endmodule

// File: tb/tb_reg_dump_port.sv
// Directed testbench for reg_dump_port with default parameters.
module tb_reg_dump_port;

    logic        clk;
    logic        reset;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        halt;
    logic        rob_empty;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        done;
    logic        late_commit;

    int total;
    int bad;

    logic [31:0] model [32];

    reg_dump_port dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .halt         (halt),
        .rob_empty    (rob_empty),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .done         (done),
        .late_commit  (late_commit)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        reset        = 1'b1;
        commit_valid = 1'b0;
        commit_rd    = 5'd0;
        commit_data  = 32'h0;
        halt         = 1'b0;
        rob_empty    = 1'b0;
        reg_addr     = 5'd0;
        #1;
        chk("rst_reg_data", reg_data, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_late", {31'b0, late_commit}, 32'h0);
        #7 reset = 1'b0;

        // Commits x5, x4, then x0 which must be dropped.
        commit_valid = 1'b1; commit_rd = 5'd5; commit_data = 32'h1234_5678;
        step(); model[5] = 32'h1234_5678;
        commit_rd = 5'd4; commit_data = 32'h0000_0444;
        step(); model[4] = 32'h0000_0444;
        commit_rd = 5'd0; commit_data = 32'hFFFF_FFFF;
        step();
        commit_valid = 1'b0;
        reg_addr = 5'd5; step();
        chk("read_x5", reg_data, 32'h1234_5678);
        reg_addr = 5'd0; step();
        chk("read_x0", reg_data, 32'h0);
        reg_addr = 5'd4; step();
        chk("read_x4", reg_data, 32'h0000_0444);

        // Write-through bypass on x7, then the stored copy.
        commit_valid = 1'b1; commit_rd = 5'd7; commit_data = 32'hDEAD_BEEF; reg_addr = 5'd7;
        step(); model[7] = 32'hDEAD_BEEF;
        chk("bypass_x7", reg_data, 32'hDEAD_BEEF);
        commit_valid = 1'b0;
        step();
        chk("shadow_x7", reg_data, 32'hDEAD_BEEF);

        // Halt, 10 quiet cycles, then a commit restarts the idle count.
        rob_empty = 1'b1; halt = 1'b1;
        step();
        halt = 1'b0; reg_addr = 5'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_early_done", {31'b0, done}, 32'h0);
        end
        commit_valid = 1'b1; commit_rd = 5'd3; commit_data = 32'h0000_0042;
        step(); model[3] = 32'h0000_0042;
        chk("drain_bypass_x3", reg_data, 32'h0000_0042);
        commit_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_restart_done", {31'b0, done}, 32'h0);
        end
        chk("drain_x3", reg_data, 32'h0000_0042);
        step();
        chk("drain_restart_done_high", {31'b0, done}, 32'h1);

        // Commit in DONE is rejected and flagged, then sweep all registers.
        commit_valid = 1'b1; commit_rd = 5'd4; commit_data = 32'h0000_0099; reg_addr = 5'd0;
        step();
        chk("late_set", {31'b0, late_commit}, 32'h1);
        commit_valid = 1'b0;
        for (int a = 0; a < 32; a++) begin
            reg_addr = 5'(a);
            step();
            chk($sformatf("sweep_x%0d", a), reg_data, model[a]);
        end
        chk("late_sticky", {31'b0, late_commit}, 32'h1);
        chk("done_sticky", {31'b0, done}, 32'h1);

        // Asynchronous reset out of DONE.
        #2 reset = 1'b1;
        #1;
        chk("arst_done", {31'b0, done}, 32'h0);
        chk("arst_late", {31'b0, late_commit}, 32'h0);
        chk("arst_reg_data", reg_data, 32'h0);
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Commit x9, enter DRAIN, then reset mid-DRAIN.
        rob_empty = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd9; commit_data = 32'h0000_0099; reg_addr = 5'd9;
        step();
        commit_valid = 1'b0;
        step();
        chk("x9_written", reg_data, 32'h0000_0099);
        rob_empty = 1'b1; halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        step();
        chk("x9_in_drain", reg_data, 32'h0000_0099);
        #2 reset = 1'b1;
        #1;
        chk("mid_drain_rst_reg_data", reg_data, 32'h0);
        chk("mid_drain_rst_done", {31'b0, done}, 32'h0);
        #2 reset = 1'b0;
        step();
        chk("x9_cleared", reg_data, 32'h0);

        // Fresh halt: done exactly 17 edges after DRAIN entry, then stays high.
        halt = 1'b1;
        step();
        chk("halt_edge_done", {31'b0, done}, 32'h0);
        halt = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("quiet_edge_%0d_done", i), {31'b0, done}, 32'h0);
        end
        step();
        chk("edge17_done", {31'b0, done}, 32'h1);
        for (int i = 0; i < 100; i++) begin
            halt = (i == 50);
            step();
            chk("done_hold", {31'b0, done}, 32'h1);
        end
        chk("no_late_after_rst", {31'b0, late_commit}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
